// File: rtl/aes_decryptor_ip_buffer_if.sv
// Handshake bundle between the OFDM receiver, the AES input buffer and the decryptor.
// The buffer uses the slave view; the surrounding logic (or a bench) uses the master view.
interface aes_decryptor_ip_buffer_if #(
  parameter int unsigned BUF_SIZE = 4,
  parameter int unsigned NO_ROWS  = 4,
  parameter int unsigned NO_COLS  = 4
);
  localparam int unsigned LW = $clog2(BUF_SIZE + 1);

  logic                                  ofdm_sdata_vld;
  logic                                  ofdm_sdata_rdy;
  logic                                  ofdm_sdata;
  logic                                  cipher_txt_vld;
  logic                                  cipher_txt_rdy;
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  cipher_txt;
  logic [LW-1:0]                         buf_level;

  modport slave (
    input  ofdm_sdata_vld, ofdm_sdata, cipher_txt_rdy,
    output ofdm_sdata_rdy, cipher_txt_vld, cipher_txt, buf_level
  );

  modport master (
    output ofdm_sdata_vld, ofdm_sdata, cipher_txt_rdy,
    input  ofdm_sdata_rdy, cipher_txt_vld, cipher_txt, buf_level
  );
endinterface

// File: rtl/aes_decryptor_ip_buffer.sv
// Receive-side input buffer of the AES decryptor: collects the serial cipher-text
// stream into NO_ROWS x NO_COLS byte blocks (row-major, bytes LSB first) and queues
// them in a BUF_SIZE-deep block FIFO towards the decryptor.
module aes_decryptor_ip_buffer #(
  parameter int unsigned BUF_SIZE = 4,
  parameter int unsigned NO_ROWS  = 4,
  parameter int unsigned NO_COLS  = 4
) (
  input  logic                     aes_clk,
  input  logic                     resetn,
  aes_decryptor_ip_buffer_if.slave bus
);
  localparam int unsigned TOTAL_BITS = 8 * NO_ROWS * NO_COLS;
  localparam int unsigned CW = $clog2(TOTAL_BITS);
  localparam int unsigned PW = $clog2(BUF_SIZE);
  localparam int unsigned LW = $clog2(BUF_SIZE + 1);

  typedef logic [TOTAL_BITS-1:0] block_t;
  typedef enum logic {ASSEMBLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt;
  block_t        asm_reg, blk_next, hold_reg, push_data;
  block_t        mem [BUF_SIZE];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count, count_d;
  logic          full, empty, sdata_rdy;
  logic          accept, last_bit, push, pop, to_hold;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept   = bus.ofdm_sdata_vld & sdata_rdy;
  assign last_bit = (bit_cnt == CW'(TOTAL_BITS - 1));
  assign pop      = ~empty & bus.cipher_txt_rdy;

  // Flat bit k of the block is cipher_txt[r][c][b]; merge in the bit offered this cycle
  always_comb begin
    blk_next          = asm_reg;
    blk_next[bit_cnt] = bus.ofdm_sdata;
  end

  // Next state, FIFO push request and push source selection
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    to_hold   = 1'b0;
    push_data = blk_next;
    case (state_q)
      ASSEMBLE: begin
        if (accept && last_bit) begin
          if (!full) begin
            push = 1'b1;
          end else begin
            to_hold = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        push_data = hold_reg;
        if (!full) begin
          push    = 1'b1;
          state_d = ASSEMBLE;
        end
      end
      default: state_d = ASSEMBLE;
    endcase
  end

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + 1'b1;
    end else if (pop && !push) begin
      count_d = count - 1'b1;
    end
  end

  // FSM state, registered input ready, bit counter and block assembly
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ASSEMBLE;
      sdata_rdy <= 1'b0;
      bit_cnt   <= '0;
      asm_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_q   <= state_d;
      sdata_rdy <= (state_d == ASSEMBLE);
      if (accept) begin
        asm_reg <= blk_next;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (to_hold) begin
        hold_reg <= blk_next;
      end
    end
  end

  // Block FIFO storage, pointers and registered full/empty flags
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < BUF_SIZE; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_d;
      full  <= (count_d == LW'(BUF_SIZE));
      empty <= (count_d == '0);
    end
  end

  assign bus.ofdm_sdata_rdy = sdata_rdy;
  assign bus.cipher_txt_vld = ~empty;
  assign bus.cipher_txt     = mem[rd_ptr];
  assign bus.buf_level      = count;

endmodule

// File: tb/tb_aes_decryptor_ip_buffer.sv
// Self-checking bench for aes_decryptor_ip_buffer: table-driven blocks plus
// hand-written backpressure, concurrent push/pop, hold-value and reset sequences.
// Every popped block is compared against a scoreboard queue filled when sent.
module tb_aes_decryptor_ip_buffer;
  localparam int unsigned BUF_SIZE = 4;
  localparam int unsigned NO_ROWS  = 4;
  localparam int unsigned NO_COLS  = 4;
  localparam int unsigned TB_BITS  = 8 * NO_ROWS * NO_COLS;

  typedef logic [TB_BITS-1:0] blk_t;
  typedef struct {
    blk_t        blk;
    bit          gapped;
    bit          rdy;
    int unsigned level;
  } vec_t;

  logic        aes_clk = 1'b0;
  logic        resetn  = 1'b0;
  bit          abort   = 1'b0;
  int unsigned n_vec   = 0;
  int unsigned n_err   = 0;
  blk_t        exp_q[$];
  vec_t        tbl[4];

  aes_decryptor_ip_buffer_if #(.BUF_SIZE(BUF_SIZE), .NO_ROWS(NO_ROWS), .NO_COLS(NO_COLS)) bus ();

  aes_decryptor_ip_buffer #(.BUF_SIZE(BUF_SIZE), .NO_ROWS(NO_ROWS), .NO_COLS(NO_COLS)) dut (
    .aes_clk (aes_clk),
    .resetn  (resetn),
    .bus     (bus.slave)
  );

  always #5 aes_clk = ~aes_clk;

  task automatic check(input string name, input blk_t act, input blk_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so a vld&rdy seen here is a pop
  always @(negedge aes_clk) begin
    if (resetn && bus.cipher_txt_vld && bus.cipher_txt_rdy) begin
      if (exp_q.size() == 0) check("pop_unexpected", blk_t'(bus.cipher_txt), '0);
      else                   check("pop_data", blk_t'(bus.cipher_txt), exp_q.pop_front());
    end
  end

  task automatic send_bit(input logic b, input bit gapped);
    int unsigned guard;
    if (abort) return;
    if (gapped) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.ofdm_sdata_vld = 1'b0;
        bus.ofdm_sdata     = 1'($urandom);
        tick();
      end
    end
    bus.ofdm_sdata_vld = 1'b1;
    bus.ofdm_sdata     = b;
    guard = 0;
    while (!bus.ofdm_sdata_rdy) begin
      if (guard == 1000) begin
        check("sdata_rdy_timeout", blk_t'(bus.ofdm_sdata_rdy), blk_t'(1));
        abort = 1'b1;
        bus.ofdm_sdata_vld = 1'b0;
        return;
      end
      tick();
      guard++;
    end
    tick();
    bus.ofdm_sdata_vld = 1'b0;
    bus.ofdm_sdata     = 1'($urandom);
  endtask

  task automatic send_bits(input blk_t blk, input int unsigned first, input int unsigned n,
                           input bit gapped);
    for (int unsigned k = first; k < first + n; k++) send_bit(blk[k], gapped);
  endtask

  task automatic send_block(input blk_t blk, input bit gapped);
    exp_q.push_back(blk);
    send_bits(blk, 0, TB_BITS, gapped);
  endtask

  task automatic drain();
    int unsigned guard = 0;
    bus.cipher_txt_rdy = 1'b1;
    while (bus.cipher_txt_vld && guard < 50) begin
      tick();
      guard++;
    end
    bus.cipher_txt_rdy = 1'b0;
    check("drain_level", blk_t'(bus.buf_level), '0);
    check("drain_scoreboard", blk_t'(exp_q.size()), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sdata_rdy"}, blk_t'(bus.ofdm_sdata_rdy), '0);
    check({tag, "_txt_vld"}, blk_t'(bus.cipher_txt_vld), '0);
    check({tag, "_txt"}, blk_t'(bus.cipher_txt), '0);
    check({tag, "_level"}, blk_t'(bus.buf_level), '0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    blk_t b1, c0, c1, c2, ha, hb, rq, rp;
    blk_t bp[5];

    b1 = 128'h32_97_fb_1d_0b_85_09_84_6a_11_dc_25_19_dc_02_39;
    tbl[0] = '{blk: {$urandom, $urandom, $urandom, $urandom}, gapped: 1'b0, rdy: 1'b0, level: 1};
    tbl[1] = '{blk: {$urandom, $urandom, $urandom, $urandom}, gapped: 1'b1, rdy: 1'b0, level: 2};
    tbl[2] = '{blk: {$urandom, $urandom, $urandom, $urandom}, gapped: 1'b0, rdy: 1'b1, level: 1};
    tbl[3] = '{blk: {$urandom, $urandom, $urandom, $urandom}, gapped: 1'b1, rdy: 1'b0, level: 2};

    bus.ofdm_sdata_vld = 1'b0;
    bus.ofdm_sdata     = 1'b0;
    bus.cipher_txt_rdy = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    check("rdy_before_first_edge", blk_t'(bus.ofdm_sdata_rdy), '0);
    tick();
    check("rdy_after_release", blk_t'(bus.ofdm_sdata_rdy), blk_t'(1));

    // Single block with vld held high
    exp_q.push_back(b1);
    send_bits(b1, 0, TB_BITS - 1, 1'b0);
    check("t1_vld_before_last", blk_t'(bus.cipher_txt_vld), '0);
    send_bit(b1[TB_BITS-1], 1'b0);
    check("t1_vld", blk_t'(bus.cipher_txt_vld), blk_t'(1));
    check("t1_level", blk_t'(bus.buf_level), blk_t'(1));
    check("t1_byte00", blk_t'(bus.cipher_txt[0][0]), blk_t'(8'h39));
    check("t1_byte01", blk_t'(bus.cipher_txt[0][1]), blk_t'(8'h02));
    check("t1_byte10", blk_t'(bus.cipher_txt[1][0]), blk_t'(8'h25));
    check("t1_byte33", blk_t'(bus.cipher_txt[3][3]), blk_t'(8'h32));
    bus.cipher_txt_rdy = 1'b1;
    tick();
    bus.cipher_txt_rdy = 1'b0;
    check("t1_level_after_pop", blk_t'(bus.buf_level), '0);
    check("t1_vld_after_pop", blk_t'(bus.cipher_txt_vld), '0);

    // Same block with a gapped stream and the decryptor always ready
    bus.cipher_txt_rdy = 1'b1;
    send_block(b1, 1'b1);
    drain();

    // Table of blocks with per-record gapping, ready and expected level
    for (int unsigned i = 0; i < 4; i++) begin
      bus.cipher_txt_rdy = tbl[i].rdy;
      send_block(tbl[i].blk, tbl[i].gapped);
      check($sformatf("tbl%0d_level", i), blk_t'(bus.buf_level), blk_t'(tbl[i].level));
      bus.cipher_txt_rdy = 1'b0;
    end
    drain();

    // Backpressure: fill the FIFO, fifth block goes to HOLD
    for (int unsigned i = 0; i < 5; i++) bp[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int unsigned i = 0; i < 4; i++) send_block(bp[i], 1'b0);
    check("t3_level_full", blk_t'(bus.buf_level), blk_t'(4));
    send_block(bp[4], 1'b1);
    check("t3_hold_rdy", blk_t'(bus.ofdm_sdata_rdy), '0);
    check("t3_hold_level", blk_t'(bus.buf_level), blk_t'(4));
    check("t3_head_b0", blk_t'(bus.cipher_txt), bp[0]);
    bus.cipher_txt_rdy = 1'b1;
    tick();
    bus.cipher_txt_rdy = 1'b0;
    check("t3_level_after_pop", blk_t'(bus.buf_level), blk_t'(3));
    check("t3_rdy_after_pop", blk_t'(bus.ofdm_sdata_rdy), '0);
    tick();
    check("t3_level_after_push", blk_t'(bus.buf_level), blk_t'(4));
    check("t3_rdy_resume", blk_t'(bus.ofdm_sdata_rdy), blk_t'(1));
    drain();

    // Concurrent push and pop at level 2
    c0 = {$urandom, $urandom, $urandom, $urandom};
    c1 = {$urandom, $urandom, $urandom, $urandom};
    c2 = {$urandom, $urandom, $urandom, $urandom};
    send_block(c0, 1'b0);
    send_block(c1, 1'b0);
    check("t4_level_before", blk_t'(bus.buf_level), blk_t'(2));
    exp_q.push_back(c2);
    send_bits(c2, 0, TB_BITS - 1, 1'b0);
    bus.cipher_txt_rdy = 1'b1;
    send_bit(c2[TB_BITS-1], 1'b0);
    bus.cipher_txt_rdy = 1'b0;
    check("t4_level_after", blk_t'(bus.buf_level), blk_t'(2));
    check("t4_head_advanced", blk_t'(bus.cipher_txt), c1);
    drain();

    // Head block stays stable while stalled and new bits arrive
    ha = {$urandom, $urandom, $urandom, $urandom};
    hb = {$urandom, $urandom, $urandom, $urandom};
    send_block(ha, 1'b0);
    exp_q.push_back(hb);
    for (int unsigned j = 0; j < 10; j++) begin
      send_bit(hb[j], 1'b0);
      check($sformatf("t6_hold_%0d", j), blk_t'(bus.cipher_txt), ha);
    end
    check("t6_vld_held", blk_t'(bus.cipher_txt_vld), blk_t'(1));
    send_bits(hb, 10, TB_BITS - 10, 1'b0);
    drain();

    // Reset with one block queued and 60 bits of the next received
    rq = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    send_block(rq, 1'b0);
    send_bits(~rp, 0, 60, 1'b0);
    resetn = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("t5_rdy_after_release", blk_t'(bus.ofdm_sdata_rdy), blk_t'(1));
    send_block(rp, 1'b0);
    check("t5_level", blk_t'(bus.buf_level), blk_t'(1));
    check("t5_block", blk_t'(bus.cipher_txt), rp);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
